// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, state encoding and control-field encodings for multicycle_ctrl
package ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b100000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000111;
  localparam logic [5:0] OP_JR   = 6'b000011;
  localparam logic [5:0] OP_JALR = 6'b001111;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MADDR  = 4'd2,
    S_MRD    = 4'd3,
    S_MWB    = 4'd4,
    S_MWR    = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_IEXE   = 4'd8,
    S_IWB    = 4'd9,
    S_BR     = 4'd10,
    S_JMP    = 4'd11,
    S_JR     = 4'd12,
    S_TRAP   = 4'd13
  } state_t;

  localparam logic [1:0] PC_ALU  = 2'b00;
  localparam logic [1:0] PC_TGT  = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_RS   = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MRD) || (s == S_MWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - saturating memory-wait counter with timeout compare
module mem_wait_timer #(
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt counts prior unready cycles, so this is the MEM_TIMEOUT-th one
  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = (cnt >= TMO_W'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle fetch/decode/execute/memory/write-back control FSM
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int OPW         = 6,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   opcode,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             jal,
  output logic             bne,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_t         state;
  logic [OPW-1:0] op_q;
  logic           waiting;
  logic           expired;

  assign waiting = is_wait_state(state);

  mem_wait_timer #(
    .TMO_W       (TMO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (!waiting || mem_ready),
    .inc     (waiting && !mem_ready),
    .expired (expired)
  );

  // Full-width compare: any set bit above the low six makes the opcode illegal
  function automatic state_t dispatch(input logic [OPW-1:0] op);
    case (op)
      OPW'(OP_R):                return S_REXE;
      OPW'(OP_LW),  OPW'(OP_SW): return S_MADDR;
      OPW'(OP_ADDI):             return S_IEXE;
      OPW'(OP_BEQ), OPW'(OP_BNE):return S_BR;
      OPW'(OP_J),   OPW'(OP_JAL):return S_JMP;
      OPW'(OP_JR),  OPW'(OP_JALR):return S_JR;
      default:                   return S_TRAP;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      op_q       <= '0;
      trap       <= 1'b0;
      trap_cause <= TC_NONE;
      retired    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            state <= S_DECODE;
          end else if (expired) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= TC_TIMEOUT;
          end
        end
        S_DECODE: begin
          op_q  <= opcode;
          state <= dispatch(opcode);
          if (dispatch(opcode) == S_TRAP) begin
            trap       <= 1'b1;
            trap_cause <= TC_ILLEGAL;
          end
        end
        S_MADDR: state <= (op_q == OPW'(OP_LW)) ? S_MRD : S_MWR;
        S_MRD: begin
          if (mem_ready) begin
            state <= S_MWB;
          end else if (expired) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= TC_TIMEOUT;
          end
        end
        S_MWR: begin
          if (mem_ready) begin
            state   <= S_FETCH;
            retired <= retired + 1'b1;
          end else if (expired) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= TC_TIMEOUT;
          end
        end
        S_REXE: state <= S_RWB;
        S_IEXE: state <= S_IWB;
        S_MWB, S_RWB, S_IWB, S_BR, S_JMP, S_JR: begin
          state   <= S_FETCH;
          retired <= retired + 1'b1;
        end
        default: state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_ADD;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    jal           = 1'b0;
    bne           = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_SHIMM;
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_REXE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IEXE: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_IWB: reg_write = 1'b1;
      S_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_TGT;
        bne           = (op_q == OPW'(OP_BNE));
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_src    = PC_JMP;
        jal       = (op_q == OPW'(OP_JAL));
        reg_write = (op_q == OPW'(OP_JAL));
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_src    = PC_RS;
        jal       = (op_q == OPW'(OP_JALR));
        reg_write = (op_q == OPW'(OP_JALR));
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl against a per-instruction cycle model
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_ADDI = 6'b000001;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_BNE  = 6'b100000;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_JAL  = 6'b000111;
  localparam logic [5:0] T_JR   = 6'b000011;
  localparam logic [5:0] T_JALR = 6'b001111;

  typedef struct packed {
    logic        mem_read;
    logic        mem_write;
    logic        i_or_d;
    logic        ir_write;
    logic        pc_write;
    logic        pc_write_cond;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        jal;
    logic        bne;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] retired;
  } ctl_t;

  typedef struct {
    ctl_t  e;
    string tag;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_src, alu_src_b, alu_op, trap_cause;
  logic        alu_src_a, reg_write, reg_dst, mem_to_reg, jal, bne, trap;
  logic [31:0] retired;

  multicycle_ctrl #(
    .OPW(6), .TMO_W(8), .MEM_TIMEOUT(TMO), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .jal(jal), .bne(bne), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int unsigned nret = 0;
  sb_t         sb[$];
  sb_t         mon_it;
  ctl_t        act;

  logic [5:0] legal [10] = '{T_R, T_LW, T_SW, T_ADDI, T_BEQ, T_BNE, T_J, T_JAL, T_JR, T_JALR};

  always_comb act = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond,
                     pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
                     mem_to_reg, jal, bne, trap, trap_cause, retired};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_it = sb.pop_front();
      tests++;
      if (act !== mon_it.e) begin
        fails++;
        $display("FAIL %s: got %h expected %h", mon_it.tag, act, mon_it.e);
      end
    end
  end

  function automatic logic [5:0] rnd_op();
    return 6'($urandom());
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom());
  endfunction

  function automatic ctl_t base();
    ctl_t c = '0;
    c.retired = nret;
    return c;
  endfunction

  task automatic cyc(input logic rdy, input logic [5:0] op, input ctl_t e, input string tag);
    mem_ready = rdy;
    opcode    = op;
    sb.push_back('{e, tag});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ctl_t c;
    nret      = 0;
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = rnd_op();
    c = base();
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'b01;
    sb.push_back('{c, "reset"});
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // A memory phase lasts waits+1 cycles, or ends in a trap once TMO unready cycles pass
  task automatic wait_phase(input bit fetch, input bit wr, input int waits, output bit to);
    ctl_t c = base();
    int   n0;
    if (fetch) begin
      c.mem_read  = 1'b1;
      c.alu_src_b = 2'b01;
    end else begin
      c.i_or_d = 1'b1;
      if (wr) c.mem_write = 1'b1;
      else    c.mem_read  = 1'b1;
    end
    n0 = (waits < TMO) ? waits : TMO;
    for (int i = 0; i < n0; i++) cyc(1'b0, rnd_op(), c, fetch ? "fetch_wait" : "mem_wait");
    to = (waits >= TMO);
    if (!to) begin
      if (fetch) begin
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
      end
      cyc(1'b1, rnd_op(), c, fetch ? "fetch_ready" : "mem_ready");
    end
  endtask

  task automatic trap_phase(input logic [1:0] cause, input int n);
    ctl_t c = base();
    c.trap       = 1'b1;
    c.trap_cause = cause;
    for (int i = 0; i < n; i++) cyc(rnd_bit(), rnd_op(), c, "trap");
  endtask

  task automatic instr(input logic [5:0] op, input int wf, input int wm);
    bit   to;
    ctl_t c;
    wait_phase(1'b1, 1'b0, wf, to);
    if (to) begin
      trap_phase(2'b10, 10);
      return;
    end
    c = base();
    c.alu_src_b = 2'b11;
    cyc(rnd_bit(), op, c, "decode");
    case (op)
      T_R: begin
        c = base(); c.alu_src_a = 1'b1; c.alu_op = 2'b10;
        cyc(rnd_bit(), rnd_op(), c, "rexe");
        c = base(); c.reg_write = 1'b1; c.reg_dst = 1'b1;
        cyc(rnd_bit(), rnd_op(), c, "rwb");
      end
      T_ADDI: begin
        c = base(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        cyc(rnd_bit(), rnd_op(), c, "iexe");
        c = base(); c.reg_write = 1'b1;
        cyc(rnd_bit(), rnd_op(), c, "iwb");
      end
      T_LW, T_SW: begin
        c = base(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        cyc(rnd_bit(), rnd_op(), c, "maddr");
        wait_phase(1'b0, op == T_SW, wm, to);
        if (to) begin
          trap_phase(2'b10, 10);
          return;
        end
        if (op == T_LW) begin
          c = base(); c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
          cyc(rnd_bit(), rnd_op(), c, "mwb");
        end
      end
      T_BEQ, T_BNE: begin
        c = base(); c.alu_src_a = 1'b1; c.alu_op = 2'b01;
        c.pc_write_cond = 1'b1; c.pc_src = 2'b01; c.bne = (op == T_BNE);
        cyc(rnd_bit(), rnd_op(), c, "branch");
      end
      T_J, T_JAL: begin
        c = base(); c.pc_write = 1'b1; c.pc_src = 2'b10;
        c.reg_write = (op == T_JAL); c.jal = (op == T_JAL);
        cyc(rnd_bit(), rnd_op(), c, "jump");
      end
      T_JR, T_JALR: begin
        c = base(); c.pc_write = 1'b1; c.pc_src = 2'b11;
        c.reg_write = (op == T_JALR); c.jal = (op == T_JALR);
        cyc(rnd_bit(), rnd_op(), c, "jump_reg");
      end
      default: begin
        trap_phase(2'b01, 100);
        return;
      end
    endcase
    nret++;
  endtask

  // R-type cut off by reset where its write-back would have happened
  task automatic abort_r();
    bit   to;
    ctl_t c;
    wait_phase(1'b1, 1'b0, 1, to);
    c = base(); c.alu_src_b = 2'b11;
    cyc(rnd_bit(), T_R, c, "decode");
    c = base(); c.alu_src_a = 1'b1; c.alu_op = 2'b10;
    cyc(rnd_bit(), rnd_op(), c, "rexe");
    do_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();
    instr(T_LW, 0, 0);
    instr(T_SW, 0, 3);
    instr(T_BNE, 0, 0);
    instr(T_BEQ, 0, 0);
    instr(T_JAL, 0, 0);
    instr(T_JALR, 0, 0);
    instr(T_R, 3, 0);
    instr(T_ADDI, 1, 0);
    instr(T_J, 0, 0);
    instr(T_JR, 0, 0);
    instr(T_LW, 2, 3);
    for (int i = 0; i < 200; i++) begin
      instr(legal[$urandom_range(9, 0)], $urandom_range(3, 0), $urandom_range(3, 0));
    end
    abort_r();
    instr(T_ADDI, 0, 0);
    instr(6'b110000, 0, 0);
    do_reset();
    instr(T_BEQ, 0, 0);
    instr(T_R, TMO, 0);
    do_reset();
    instr(T_LW, 0, TMO);
    do_reset();
    instr(T_SW, 1, TMO + 1);
    do_reset();
    instr(T_BNE, 0, 0);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the processor datapath. It replaces per-instruction combinational decode with a state machine that sequences fetch, decode, execute, memory and write-back over several cycles, and waits on a shared instruction/data memory through a ready handshake. It also adds two things: a memory-wait timeout and a sticky trap for illegal opcodes or bus errors. It sits between the instruction register and the datapath muxes, register file, ALU control and memory port.

## Interface
- `OPW`, 6: opcode width; opcodes are compared on the low 6 bits, and upper bits must be zero or the opcode is illegal.
- `TMO_W`, 8: width of the memory-wait timeout counter.
- `MEM_TIMEOUT`, 200: maximum cycles to wait for `mem_ready` before trapping; 0 disables the timeout.
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; forces `S_FETCH`, clears the counters and the trap.
- `opcode` in OPW: opcode from the instruction register; sampled in `S_DECODE`.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `mem_read`, `mem_write` out 1: memory request; held until the cycle `mem_ready`=1.
- `i_or_d` out 1: memory address select; 0 = PC, 1 = ALU out.
- `ir_write`, `pc_write`, `pc_write_cond` out 1: register enables.
- `pc_src` out 2: PC source; 00 = ALU, 01 = ALU out (branch target), 10 = jump target, 11 = rs.
- `alu_src_a` out 1: ALU A select; 0 = PC, 1 = rs.
- `alu_src_b` out 2: ALU B select; 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `alu_op` out 2: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- `reg_write`, `reg_dst`, `mem_to_reg`, `jal`, `bne` out 1: write-back and branch qualifiers.
- `trap` out 1: sticky error flag.
- `trap_cause` out 2: 01 = illegal opcode, 10 = bus timeout.
- `retired` out CNT_W: count of completed instructions.

## Operation
- States: `S_FETCH`, `S_DECODE`, `S_MADDR`, `S_MRD`, `S_MWB`, `S_MWR`, `S_REXE`, `S_RWB`, `S_IEXE`, `S_IWB`, `S_BR`, `S_JMP`, `S_JR`, `S_TRAP`.
- Any output not listed for a state is 0.
- `S_FETCH`:
  - Asserts `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01.
  - When `mem_ready`=1: also asserts `ir_write`=1 and `pc_write`=1 with `pc_src`=00, then moves to `S_DECODE`.
  - Otherwise stays in `S_FETCH`.
- `S_DECODE`: asserts `alu_src_b`=11 (branch target precompute), then dispatches on opcode:
  - 000000 → `S_REXE`
  - 100011, 101011 → `S_MADDR`
  - 000001 → `S_IEXE`
  - 000100, 100000 → `S_BR`
  - 000010, 000111 → `S_JMP`
  - 000011, 001111 → `S_JR`
  - any other value → `S_TRAP` with `trap_cause`=01
- `S_MADDR`: `alu_src_a`=1, `alu_src_b`=10. Goes to `S_MRD` for lw, `S_MWR` for sw.
- `S_MRD`: `mem_read`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to `S_MWB`.
- `S_MWB`: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to `S_FETCH`.
- `S_MWR`: `mem_write`=1, `i_or_d`=1. Waits for `mem_ready`, then goes to `S_FETCH`.
- `S_REXE`: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to `S_RWB`.
- `S_RWB`: `reg_write`=1, `reg_dst`=1. Goes to `S_FETCH`.
- `S_IEXE`: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to `S_IWB`.
- `S_IWB`: `reg_write`=1, `reg_dst`=0. Goes to `S_FETCH`.
- `S_BR`: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_src`=01. `bne`=1 for opcode 100000, otherwise 0. Goes to `S_FETCH`.
- `S_JMP`: `pc_write`=1, `pc_src`=10. For jal (000111) also `reg_write`=1 and `jal`=1. Goes to `S_FETCH`.
- `S_JR`: `pc_write`=1, `pc_src`=11. For jalr (001111) also `reg_write`=1 and `jal`=1. Goes to `S_FETCH`.
- The opcode is latched into an internal register in `S_DECODE`. Later states use only the latched copy, never the live `opcode` input.
- `retired` increments by 1 on every transition into `S_FETCH` from any state other than `S_FETCH` itself. It wraps modulo 2^CNT_W.
- Timeout counter:
  - Clears on entry to any wait state (`S_FETCH`, `S_MRD`, `S_MWR`).
  - Increments each cycle the state is waiting with `mem_ready`=0.
  - If it reaches `MEM_TIMEOUT` with `mem_ready` still 0, the next state is `S_TRAP` with `trap_cause`=10.
  - `mem_ready`=1 on the same cycle the count is reached wins: normal transition, no trap.
  - The counter saturates and does not wrap.
- `S_TRAP`: all enables are 0 and `trap`=1. Absorbing; only `reset` exits it.

## Timing
- Reset values: state = `S_FETCH`, `retired`=0, `trap`=0, `trap_cause`=00, timeout counter = 0, latched opcode = 0.
- After reset the outputs are exactly those of `S_FETCH`, so `mem_read`=1 immediately.
- All outputs are a Moore decode of the state. The exceptions are:
  - `ir_write` and `pc_write` in `S_FETCH`, which are gated by `mem_ready`.
  - `jal` and `bne`, which decode from the latched opcode.
- Cycle counts with zero-wait memory:
  - lw: 5 cycles.
  - R-type, addi and sw: 4 cycles.
  - beq, bne, j, jal, jr and jalr: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Reset asserted mid-instruction aborts it immediately (asynchronous). No partial register write occurs after reset asserts.
- `mem_read` and `mem_write` never both equal 1.

## Structure
- Package `ctrl_pkg` holds:
  - opcode localparams (OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JR, OP_JAL, OP_JALR);
  - the state encoding localparams;
  - the `pc_src`, `alu_src_b`, `alu_op` and `trap_cause` encodings.
- One sub-module, `mem_wait_timer`, contains the clear/increment/saturate counter and the `expired` compare, parameterised by `TMO_W` and `MEM_TIMEOUT`.

## Test plan
- **lw, zero wait.** Reset, then opcode 100011 with `mem_ready`=1 throughout → states FETCH, DECODE, MADDR, MRD, MWB; `reg_write`=1 only in cycle 5 with `mem_to_reg`=1; `retired`=1.
- **sw with wait.** Opcode 101011 with `mem_ready` held low for 3 cycles in `S_MWR` → `mem_write` high for 4 cycles, `i_or_d`=1, 7 cycles total.
- **bne vs beq.** Opcode 100000 → `S_BR` with `bne`=1, `pc_write_cond`=1, `pc_src`=01; repeating with 000100 gives `bne`=0.
- **jal then jalr.** jal → `pc_src`=10, `reg_write`=1, `jal`=1; jalr → `pc_src`=11, `reg_write`=1, `jal`=1; `retired` advances by 2.
- **Illegal opcode.** Opcode 110000 → `trap`=1, `trap_cause`=01, all enables 0; stays trapped for 100 cycles; `reset` returns to `S_FETCH`.
- **Timeout.** `MEM_TIMEOUT`=4 and `mem_ready`=0 in `S_FETCH` → `S_TRAP` with `trap_cause`=10 after 4 wait cycles. Repeat with `mem_ready`=1 on the 4th cycle → no trap.
